// File: rtl/opensync_pkg.sv
// Shared OpenSync constants, FSM encodings and the delay-line entry type
// used by the transmit PIT stamping path.
package opensync_pkg;

    localparam logic [15:0] OPENSYNC_ETH_TYPE = 16'hFF01;
    localparam logic [7:0]  OPENSYNC_SUBTYPE  = 8'h06;
    localparam logic [7:0]  OPENSYNC_MSG_TYPE = 8'h03;
    localparam int          TX_PIT_OFFSET     = 24;
    localparam int          RX_PIT_OFFSET     = 32;
    localparam int          DELAY_STAGES      = 16;
    localparam logic [5:0]  BYTE_CNT_MAX      = 6'd63;

    typedef enum logic [1:0] {
        IDLE_S         = 2'd0,
        STAMP_S        = 2'd1,
        TRANSMIT_PKT_S = 2'd2
    } opensync_state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } dl_entry_t;

    // Big-endian byte of a 64-bit timestamp; offset 0 is the MSB.
    function automatic logic [7:0] pit_byte(input logic [63:0] t, input logic [5:0] offset);
        logic [7:0] b;
        case (offset)
            6'd0:    b = t[63:56];
            6'd1:    b = t[55:48];
            6'd2:    b = t[47:40];
            6'd3:    b = t[39:32];
            6'd4:    b = t[31:24];
            6'd5:    b = t[23:16];
            6'd6:    b = t[15:8];
            6'd7:    b = t[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/opensync_crc32_d8.sv
// Byte-wide reflected CRC-32 (poly 0xEDB88320) next-state function.
// No init or final XOR here; the caller owns both.
module opensync_crc32_d8 (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            if (r[0]) begin
                r = (r >> 1) ^ 32'hEDB88320;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    // Pure combinational update.
    always_comb begin
        crc_out = crc32_step(crc_in, data_in);
    end

endmodule

// File: rtl/opensync_transmit_pit_record.sv
// Transmit-side PIT stamping: delays frames 16 cycles and writes the latched
// transmit time into bytes 24..31 of OpenSync frames. OPENSYNC_TX_CRC_REGEN_EN regenerates the FCS.
module opensync_transmit_pit_record
    import opensync_pkg::*;
#(
    parameter logic [63:0] TX_TIME_ADJ = 64'd0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] iv_local_time,
    input  logic [7:0]  iv_data,
    input  logic        i_data_wr,
    output logic [7:0]  ov_data,
    output logic        o_data_wr
);

    // The registered output is the final stage, so the line holds one fewer entry.
    localparam int         HEAD_IDX  = DELAY_STAGES - 2;
    localparam logic [5:0] PIT_FIRST = 6'(TX_PIT_OFFSET);
    localparam logic [5:0] PIT_LAST  = 6'(TX_PIT_OFFSET + 7);

    logic            armed_r;
    logic            in_valid_s;
    logic            first_byte_s;
    logic [5:0]      in_cnt_r;
    logic [63:0]     in_time_r;
    logic [63:0]     stamp_time_r;
    dl_entry_t       dl_r [0:HEAD_IDX];
    dl_entry_t       head_s;
    logic            line_full_s;
    logic            is_opensync_s;
    opensync_state_t state_r;
    opensync_state_t next_state_s;
    logic [5:0]      out_idx_r;
    logic [5:0]      next_idx_s;
    logic            frame_start_s;
    logic [7:0]      fsm_data_s;
    logic [7:0]      out_data_s;
    logic            out_wr_s;
    logic [7:0]      ov_data_r;
    logic            o_data_wr_r;

    // After reset, ignore the frame in flight until a low i_data_wr is seen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            armed_r <= 1'b0;
        end else if (!i_data_wr) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end

    // Input qualification and frame-start detection.
    always_comb begin
        in_valid_s   = i_data_wr & armed_r;
        first_byte_s = in_valid_s && (in_cnt_r == 6'd0);
    end

    // Saturating input byte counter and transmit-time latch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_cnt_r  <= 6'd0;
            in_time_r <= 64'd0;
        end else begin
            if (!in_valid_s) begin
                in_cnt_r <= 6'd0;
            end else if (in_cnt_r != BYTE_CNT_MAX) begin
                in_cnt_r <= in_cnt_r + 6'd1;
            end else begin
                in_cnt_r <= in_cnt_r;
            end
            if (first_byte_s) begin
                in_time_r <= iv_local_time + TX_TIME_ADJ;
            end else begin
                in_time_r <= in_time_r;
            end
        end
    end

    // Delay line shift; invalid entries carry zero data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i <= HEAD_IDX; i++) begin
                dl_r[i] <= '0;
            end
        end else begin
            dl_r[0].valid <= in_valid_s;
            dl_r[0].data  <= in_valid_s ? iv_data : 8'h00;
            for (int i = 1; i <= HEAD_IDX; i++) begin
                dl_r[i] <= dl_r[i-1];
            end
        end
    end

    // Classification with byte 0 at the head: bytes 12..14 sit in the line, byte 15 at the input.
    always_comb begin
        head_s      = dl_r[HEAD_IDX];
        line_full_s = in_valid_s;
        for (int i = 0; i <= HEAD_IDX; i++) begin
            line_full_s = line_full_s & dl_r[i].valid;
        end
        is_opensync_s = line_full_s
                     && ({dl_r[HEAD_IDX-12].data, dl_r[HEAD_IDX-13].data} == OPENSYNC_ETH_TYPE)
                     && (dl_r[HEAD_IDX-14].data == OPENSYNC_SUBTYPE)
                     && (iv_data == OPENSYNC_MSG_TYPE);
        frame_start_s = (state_r == IDLE_S) && head_s.valid;
    end

    // Output FSM next-state and byte selection.
    always_comb begin
        next_state_s = state_r;
        next_idx_s   = out_idx_r;
        fsm_data_s   = 8'h00;
        out_wr_s     = 1'b0;
        case (state_r)
            IDLE_S: begin
                if (head_s.valid) begin
                    out_wr_s     = 1'b1;
                    fsm_data_s   = head_s.data;
                    next_idx_s   = 6'd1;
                    next_state_s = is_opensync_s ? STAMP_S : TRANSMIT_PKT_S;
                end else begin
                    next_idx_s   = 6'd0;
                    next_state_s = IDLE_S;
                end
            end
            STAMP_S: begin
                if (head_s.valid) begin
                    out_wr_s   = 1'b1;
                    next_idx_s = out_idx_r + 6'd1;
                    if (out_idx_r >= PIT_FIRST) begin
                        fsm_data_s = pit_byte(stamp_time_r, out_idx_r - PIT_FIRST);
                    end else begin
                        fsm_data_s = head_s.data;
                    end
                    if (out_idx_r == PIT_LAST) begin
                        next_state_s = TRANSMIT_PKT_S;
                    end else begin
                        next_state_s = STAMP_S;
                    end
                end else begin
                    next_idx_s   = 6'd0;
                    next_state_s = IDLE_S;
                end
            end
            TRANSMIT_PKT_S: begin
                if (head_s.valid) begin
                    out_wr_s     = 1'b1;
                    fsm_data_s   = head_s.data;
                    next_state_s = TRANSMIT_PKT_S;
                end else begin
                    next_idx_s   = 6'd0;
                    next_state_s = IDLE_S;
                end
            end
            default: begin
                next_idx_s   = 6'd0;
                next_state_s = IDLE_S;
            end
        endcase
    end

    // FSM state, output byte index and per-frame stamp time.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= IDLE_S;
            out_idx_r    <= 6'd0;
            stamp_time_r <= 64'd0;
        end else begin
            state_r   <= next_state_s;
            out_idx_r <= next_idx_s;
            if (frame_start_s) begin
                stamp_time_r <= in_time_r;
            end else begin
                stamp_time_r <= stamp_time_r;
            end
        end
    end

`ifdef OPENSYNC_TX_CRC_REGEN_EN
    logic [31:0] crc_r;
    logic [31:0] crc_seed_s;
    logic [31:0] crc_next_s;
    logic        long_r;
    logic        fcs_s;

    // Last four bytes: the entry four stages younger than the head is empty.
    always_comb begin
        fcs_s      = head_s.valid && !dl_r[HEAD_IDX-4].valid && long_r && (state_r != IDLE_S);
        crc_seed_s = frame_start_s ? 32'hFFFFFFFF : crc_r;
        out_data_s = fcs_s ? ~crc_r[7:0] : fsm_data_s;
    end

    opensync_crc32_d8 u_crc (
        .crc_in  (crc_seed_s),
        .data_in (fsm_data_s),
        .crc_out (crc_next_s)
    );

    // CRC accumulates stamped bytes, then shifts out LSB-first over the FCS.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            crc_r  <= 32'hFFFFFFFF;
            long_r <= 1'b0;
        end else if (frame_start_s) begin
            crc_r  <= crc_next_s;
            long_r <= dl_r[HEAD_IDX-4].valid;
        end else if (fcs_s) begin
            crc_r  <= {8'hFF, crc_r[31:8]};
            long_r <= long_r;
        end else if (head_s.valid) begin
            crc_r  <= crc_next_s;
            long_r <= long_r;
        end else begin
            crc_r  <= crc_r;
            long_r <= long_r;
        end
    end
`else
    // FCS passes through untouched.
    always_comb begin
        out_data_s = fsm_data_s;
    end
`endif

    // Registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_data_r   <= 8'h00;
            o_data_wr_r <= 1'b0;
        end else begin
            ov_data_r   <= out_wr_s ? out_data_s : 8'h00;
            o_data_wr_r <= out_wr_s;
        end
    end

    assign ov_data   = ov_data_r;
    assign o_data_wr = o_data_wr_r;

endmodule

// File: tb/tb_opensync_transmit_pit_record.sv
// Scoreboard bench for opensync_transmit_pit_record: the driver queues expected
// output bytes with their due cycle; a negedge monitor pops and compares.
module tb_opensync_transmit_pit_record;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [63:0] iv_local_time = 64'd0;
    logic [7:0]  iv_data = 8'h00;
    logic        i_data_wr = 1'b0;
    logic [7:0]  ov_data;
    logic        o_data_wr;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    opensync_transmit_pit_record #(.TX_TIME_ADJ(64'd0)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .iv_local_time (iv_local_time),
        .iv_data       (iv_data),
        .i_data_wr     (i_data_wr),
        .ov_data       (ov_data),
        .o_data_wr     (o_data_wr)
    );

    always #4 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

`ifdef OPENSYNC_TX_CRC_REGEN_EN
    function automatic logic [31:0] crc_ref(input logic [7:0] b[$], input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h000000, b[i]};
            for (int j = 0; j < 8; j++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction
`endif

    // Drive one frame; bytes due after a reset pulse at rst_at are not expected.
    task automatic send_frame(input int len, input logic [63:0] t0, input bit ops_hdr,
                              input logic [7:0] b15, input int rst_at);
        logic [7:0] fr[$];
        logic [7:0] ex[$];
        bit         is_ops;
        exp_t       e;
`ifdef OPENSYNC_TX_CRC_REGEN_EN
        logic [31:0] c;
`endif
        for (int k = 0; k < len; k++) begin
            logic [7:0] b;
            b = 8'((k * 29) + len + 3);
            if (k == 12) b = ops_hdr ? 8'hFF : 8'h08;
            if (k == 13) b = ops_hdr ? 8'h01 : 8'h00;
            if (k == 14) b = ops_hdr ? 8'h06 : 8'h45;
            if (k == 15) b = b15;
            fr.push_back(b);
        end
        ex = fr;
        is_ops = ops_hdr && (len >= 16) && (b15 == 8'h03);
        if (is_ops) begin
            for (int k = 24; k < 32 && k < len; k++) begin
                ex[k] = t0[63 - 8 * (k - 24) -: 8];
            end
        end
`ifdef OPENSYNC_TX_CRC_REGEN_EN
        if (len >= 5) begin
            c = crc_ref(ex, len - 4);
            for (int j = 0; j < 4; j++) ex[len - 4 + j] = c[8 * j +: 8];
        end
`endif
        for (int k = 0; k < len; k++) begin
            @(posedge i_clk);
            #1;
            i_data_wr     = 1'b1;
            iv_data       = fr[k];
            iv_local_time = t0 + 64'(k) * 64'h0000_0000_0101_1111;
            if (rst_at < 0 || (k + 16) < rst_at) begin
                e.data = ex[k];
                e.cyc  = cyc + 16;
                sb_q.push_back(e);
            end
            if (k == rst_at) i_rst_n = 1'b0;
            if (k == rst_at + 2) i_rst_n = 1'b1;
        end
        @(posedge i_clk);
        #1;
        i_data_wr     = 1'b0;
        iv_data       = 8'hA5;
        iv_local_time = 64'hDEAD_BEEF_0000_0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Monitor: compare each valid output byte (value and cycle) against the queue head.
    always @(negedge i_clk) begin
        exp_t e;
        if (o_data_wr) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got %02h at cycle %0d, expected no output", ov_data, cyc);
            end else begin
                e = sb_q.pop_front();
                if (ov_data !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL out_byte: got %02h at cycle %0d, expected %02h at cycle %0d",
                             ov_data, cyc, e.data, e.cyc);
                end
            end
        end else begin
            checks++;
            if (ov_data !== 8'h00) begin
                errors++;
                $display("FAIL idle_data: got %02h while o_data_wr low, expected 00", ov_data);
            end
            if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
                errors++;
                e = sb_q.pop_front();
                $display("FAIL missing_byte: got no output at cycle %0d, expected %02h", cyc, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        checks++;
        if (o_data_wr !== 1'b0 || ov_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got wr=%b data=%02h, expected wr=0 data=00", o_data_wr, ov_data);
        end
        i_rst_n = 1'b1;
        idle(3);

        // Stamp 0x0000_0001_0000_0000 into a 64-byte OpenSync frame.
        send_frame(64, 64'h0000_0001_0000_0000, 1'b1, 8'h03, -1);
        // Message type 04: not OpenSync, passes unchanged.
        send_frame(64, 64'h0000_0000_0000_0055, 1'b1, 8'h04, -1);
        // Back-to-back frames with a single idle cycle keep their own times.
        send_frame(64, 64'd100, 1'b1, 8'h03, -1);
        send_frame(64, 64'd200, 1'b1, 8'h03, -1);
        // Truncated OpenSync frame, then an ordinary frame.
        send_frame(28, 64'h0123_4567_89AB_CDEF, 1'b1, 8'h03, -1);
        send_frame(40, 64'h0000_0000_0000_0077, 1'b0, 8'h00, -1);
        // Short frames.
        send_frame(10, 64'h0000_0000_0000_0011, 1'b1, 8'h03, -1);
        send_frame(16, 64'h0000_0000_0000_0022, 1'b1, 8'h03, -1);
        send_frame(5,  64'h0000_0000_0000_0033, 1'b0, 8'h00, -1);
        send_frame(4,  64'h0000_0000_0000_0044, 1'b0, 8'h00, -1);
        send_frame(1,  64'h0000_0000_0000_0055, 1'b0, 8'h00, -1);
        idle(3);
        // Reset at byte 20 discards the frame; the next one resumes normally.
        send_frame(40, 64'h0000_0000_0000_0099, 1'b1, 8'h03, 20);
        idle(2);
        send_frame(64, 64'hFEDC_BA98_7654_3210, 1'b1, 8'h03, -1);
        idle(40);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d bytes still pending, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
